// File: rtl/comp_pkg.sv
// comp_pkg: shared definitions for the comp_track streaming comparator.
//   - trk_state_t : tracker FSM state encoding (TRK_EMPTY, TRK_TRACK)
//   - CMP_UNSIGNED / CMP_SIGNED : compare-mode constants carried on sgn
//   - rel_t : one-hot relation encoding packed as {gt, lt, eq}
package comp_pkg;

   typedef enum logic {
      TRK_EMPTY = 1'b0,
      TRK_TRACK = 1'b1
   } trk_state_t;

   localparam logic CMP_UNSIGNED = 1'b0;
   localparam logic CMP_SIGNED   = 1'b1;

   // Bit order matches the {gt, lt, eq} output grouping.
   typedef enum logic [2:0] {
      REL_NONE = 3'b000,
      REL_EQ   = 3'b001,
      REL_LT   = 3'b010,
      REL_GT   = 3'b100
   } rel_t;

endpackage

// File: rtl/comp_cell.sv
// comp_cell: combinational DATAWIDTH-bit magnitude compare of a against b.
// Ports:
//   a, b  in  DATAWIDTH operands
//   mode  in  CMP_SIGNED for two's-complement, CMP_UNSIGNED otherwise
//   rel   out one-hot {gt, lt, eq}
module comp_cell
   import comp_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic                 mode,
   output logic [2:0]           rel
);

   logic [DATAWIDTH-1:0] a_key;
   logic [DATAWIDTH-1:0] b_key;

   // Flipping the sign bit maps two's-complement order onto unsigned order,
   // so one unsigned comparator serves both modes at the native width.
   assign a_key = {a[DATAWIDTH-1] ^ (mode == CMP_SIGNED), a[DATAWIDTH-2:0]};
   assign b_key = {b[DATAWIDTH-1] ^ (mode == CMP_SIGNED), b[DATAWIDTH-2:0]};

   always_comb begin
      rel = REL_EQ;
      if (a_key > b_key) begin
         rel = REL_GT;
      end else if (a_key < b_key) begin
         rel = REL_LT;
      end
   end

endmodule

// File: rtl/comp_track.sv
// comp_track: registered signed/unsigned compare of a vs b, plus a per-frame
// tracker of the a stream (running max, min, saturating sample count).
// Ports:
//   Clk, Rst            clock, asynchronous active-low reset
//   in_valid            qualifies a, b, sgn this cycle
//   a, b, sgn           operands and compare mode (1 = signed)
//   clr                 synchronous frame clear for the tracker only
//   out_valid, gt/lt/eq registered compare result (1-cycle latency)
//   max_val, min_val    running extremes of a in the current frame
//   cnt, sat            saturating sample count and sticky saturation flag
//   trk_valid           frame holds at least one sample
//   mode_err            sticky: a sample's sgn differed from the frame mode
//   trk_state           current tracker FSM state (debug visibility)
//
// Handshake: in_valid marks a sample that is always accepted on that rising
// edge (no ready, no stall); out_valid pulses for exactly one cycle per
// accepted sample, and the flags hold their value while out_valid is low.
module comp_track
   import comp_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int CNTWIDTH  = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic                 sgn,
   input  logic                 clr,
   output logic                 out_valid,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq,
   output logic [DATAWIDTH-1:0] max_val,
   output logic [DATAWIDTH-1:0] min_val,
   output logic [CNTWIDTH-1:0]  cnt,
   output logic                 sat,
   output logic                 trk_valid,
   output logic                 mode_err,
   output logic                 trk_state
);

   localparam logic [CNTWIDTH-1:0] CNT_ONE = {{(CNTWIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};

   trk_state_t           state_q, state_n;
   logic [DATAWIDTH-1:0] max_q, max_n;
   logic [DATAWIDTH-1:0] min_q, min_n;
   logic [CNTWIDTH-1:0]  cnt_q, cnt_n;
   logic                 sat_q, sat_n;
   logic                 merr_q, merr_n;
   logic                 tsgn_q, tsgn_n;
   logic [2:0]           rel_q;

   logic [2:0]           rel_ab;
   logic [2:0]           rel_max;
   logic [2:0]           rel_min;
   logic                 unused_rel;

   comp_cell #(.DATAWIDTH(DATAWIDTH)) u_cmp_ab (
      .a    (a),
      .b    (b),
      .mode (sgn),
      .rel  (rel_ab)
   );

   // Extremes are compared in the frame's latched mode, not the sample's.
   comp_cell #(.DATAWIDTH(DATAWIDTH)) u_cmp_max (
      .a    (a),
      .b    (max_q),
      .mode (tsgn_q),
      .rel  (rel_max)
   );

   comp_cell #(.DATAWIDTH(DATAWIDTH)) u_cmp_min (
      .a    (a),
      .b    (min_q),
      .mode (tsgn_q),
      .rel  (rel_min)
   );

   assign unused_rel = &{1'b0, rel_max[1:0], rel_min[2], rel_min[0]};

   // Compare path: ignores clr entirely.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         out_valid <= 1'b0;
         rel_q     <= REL_NONE;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            rel_q <= rel_ab;
         end
      end
   end

   // Tracker state register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= TRK_EMPTY;
         max_q   <= '0;
         min_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         merr_q  <= 1'b0;
         tsgn_q  <= CMP_UNSIGNED;
      end else begin
         state_q <= state_n;
         max_q   <= max_n;
         min_q   <= min_n;
         cnt_q   <= cnt_n;
         sat_q   <= sat_n;
         merr_q  <= merr_n;
         tsgn_q  <= tsgn_n;
      end
   end

   // Tracker next state. A clr arriving with a sample starts a new frame with
   // that sample, so clr and EMPTY share the frame-load path.
   always_comb begin
      state_n = state_q;
      max_n   = max_q;
      min_n   = min_q;
      cnt_n   = cnt_q;
      sat_n   = sat_q;
      merr_n  = merr_q;
      tsgn_n  = tsgn_q;
      if (clr || (state_q == TRK_EMPTY)) begin
         if (in_valid) begin
            state_n = TRK_TRACK;
            max_n   = a;
            min_n   = a;
            cnt_n   = CNT_ONE;
            sat_n   = 1'b0;
            merr_n  = 1'b0;
            tsgn_n  = sgn;
         end else if (clr) begin
            state_n = TRK_EMPTY;
            max_n   = '0;
            min_n   = '0;
            cnt_n   = '0;
            sat_n   = 1'b0;
            merr_n  = 1'b0;
         end
      end else if (in_valid) begin
         if (rel_max == REL_GT) begin
            max_n = a;
         end
         if (rel_min == REL_LT) begin
            min_n = a;
         end
         if (cnt_q == CNT_MAX) begin
            sat_n = 1'b1;
         end else begin
            cnt_n = cnt_q + CNT_ONE;
         end
         if (sgn != tsgn_q) begin
            merr_n = 1'b1;
         end
      end
   end

   assign gt        = rel_q[2];
   assign lt        = rel_q[1];
   assign eq        = rel_q[0];
   assign max_val   = max_q;
   assign min_val   = min_q;
   assign cnt       = cnt_q;
   assign sat       = sat_q;
   assign mode_err  = merr_q;
   assign trk_valid = (state_q == TRK_TRACK);
   assign trk_state = state_q;

endmodule

// File: tb/tb_comp_track.sv
// tb_comp_track: directed bench for comp_track. Two instances share one
// stimulus stream: an 8-bit counter build and a 2-bit counter build that
// reaches saturation quickly. A frame-level model (the list of samples in the
// current frame) predicts every output; literal checks pin the model.
module tb_comp_track;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       sgn = 1'b0;
   logic       clr = 1'b0;

   logic       ov8, gt8, lt8, eq8, sat8, tv8, me8, st8;
   logic [7:0] mx8, mn8, cnt8;
   logic       ov2, gt2, lt2, eq2, sat2, tv2, me2, st2;
   logic [7:0] mx2, mn2;
   logic [1:0] cnt2;

   int checks = 0;
   int failures = 0;

   logic [2:0] exp_q[$];
   logic [7:0] frame_a[$];
   logic       frame_s[$];
   logic [2:0] held_rel = 3'b000;

   // ---------------- clock / reset ----------------
   always #5 Clk = ~Clk;

   comp_track #(.DATAWIDTH(8), .CNTWIDTH(8)) u8 (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .a(a), .b(b), .sgn(sgn),
      .clr(clr), .out_valid(ov8), .gt(gt8), .lt(lt8), .eq(eq8),
      .max_val(mx8), .min_val(mn8), .cnt(cnt8), .sat(sat8),
      .trk_valid(tv8), .mode_err(me8), .trk_state(st8)
   );

   comp_track #(.DATAWIDTH(8), .CNTWIDTH(2)) u2 (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .a(a), .b(b), .sgn(sgn),
      .clr(clr), .out_valid(ov2), .gt(gt2), .lt(lt2), .eq(eq2),
      .max_val(mx2), .min_val(mn2), .cnt(cnt2), .sat(sat2),
      .trk_valid(tv2), .mode_err(me2), .trk_state(st2)
   );

   // ---------------- model ----------------
   function automatic int sval(logic [7:0] x, logic s);
      if (s) return int'($signed(x));
      return int'({24'd0, x});
   endfunction

   function automatic logic [2:0] rel_of(logic [7:0] x, logic [7:0] y, logic s);
      if (sval(x, s) > sval(y, s)) return 3'b100;
      if (sval(x, s) < sval(y, s)) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [7:0] frame_ext(bit want_max);
      logic [7:0] m;
      if (frame_a.size() == 0) return 8'h00;
      m = frame_a[0];
      foreach (frame_a[i]) begin
         if (want_max && sval(frame_a[i], frame_s[0]) > sval(m, frame_s[0])) m = frame_a[i];
         if (!want_max && sval(frame_a[i], frame_s[0]) < sval(m, frame_s[0])) m = frame_a[i];
      end
      return m;
   endfunction

   function automatic logic frame_merr();
      foreach (frame_s[i]) if (frame_s[i] != frame_s[0]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         exp_q.delete();
         frame_a.delete();
         frame_s.delete();
      end else begin
         if (in_valid) exp_q.push_back(rel_of(a, b, sgn));
         if (clr) begin
            frame_a.delete();
            frame_s.delete();
         end
         if (in_valid) begin
            frame_a.push_back(a);
            frame_s.push_back(sgn);
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_dut(string tag, logic ov, logic g, logic l, logic e,
                            logic [7:0] mx, logic [7:0] mn, logic [7:0] c,
                            logic s, logic tv, logic me, logic eov,
                            logic [2:0] erel, int cmax);
      int n;
      n = frame_a.size();
      chk({tag, ".out_valid"}, ov, eov);
      chk({tag, ".flags"}, {g, l, e}, erel);
      chk({tag, ".max_val"}, mx, frame_ext(1'b1));
      chk({tag, ".min_val"}, mn, frame_ext(1'b0));
      chk({tag, ".cnt"}, c, (n > cmax) ? cmax : n);
      chk({tag, ".sat"}, s, n > cmax);
      chk({tag, ".trk_valid"}, tv, n > 0);
      chk({tag, ".mode_err"}, me, frame_merr());
   endtask

   always @(negedge Clk) begin
      logic eov;
      if (!Rst) held_rel = 3'b000;
      eov = 1'b0;
      if (exp_q.size() > 0) begin
         held_rel = exp_q.pop_front();
         eov = 1'b1;
      end
      check_dut("u8", ov8, gt8, lt8, eq8, mx8, mn8, cnt8, sat8, tv8, me8, eov, held_rel, 255);
      check_dut("u2", ov2, gt2, lt2, eq2, mx2, mn2, {6'd0, cnt2}, sat2, tv2, me2, eov, held_rel, 3);
   end

   // ---------------- drivers ----------------
   task automatic drive(logic v, logic [7:0] av, logic [7:0] bv, logic s, logic c);
      @(negedge Clk);
      in_valid = v;
      a = av;
      b = bv;
      sgn = s;
      clr = c;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1 Rst = 1'b0;
      #2;
      chk("reset.out_valid", ov8, 1'b0);
      chk("reset.flags", {gt8, lt8, eq8}, 3'b000);
      chk("reset.cnt", cnt8, 8'd0);
      chk("reset.trk_valid", tv8, 1'b0);
      repeat (2) @(negedge Clk);
      #2 Rst = 1'b1;

      // 0x80 vs 0x7F: unsigned greater, signed less.
      drive(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
      drive(1'b1, 8'h80, 8'h7F, 1'b1, 1'b0);
      #1;
      chk("lit.unsigned_gt", {ov8, gt8, lt8, eq8}, 4'b1100);
      idle();
      chk("lit.signed_lt", {ov8, gt8, lt8, eq8}, 4'b1010);

      // Equal for one cycle, then flags hold while out_valid drops.
      drive(1'b1, 8'h55, 8'h55, 1'b0, 1'b0);
      idle();
      chk("lit.eq_valid", {ov8, eq8}, 2'b11);
      idle();
      chk("lit.eq_hold", {ov8, gt8, lt8, eq8}, 4'b0001);

      // Unsigned frame 5, 250, 3.
      drive(1'b1, 8'd5, 8'd0, 1'b0, 1'b1);
      drive(1'b1, 8'd250, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 8'd3, 8'd0, 1'b0, 1'b0);
      idle();
      chk("lit.u_max", mx8, 8'd250);
      chk("lit.u_min", mn8, 8'd3);
      chk("lit.u_cnt", cnt8, 8'd3);
      chk("lit.u_trk_valid", tv8, 1'b1);
      chk("lit.model_max", frame_ext(1'b1), 8'd250);

      // Signed frame 0x05, 0xFA, 0x03.
      drive(1'b1, 8'h05, 8'h00, 1'b1, 1'b1);
      drive(1'b1, 8'hFA, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'h03, 8'h00, 1'b1, 1'b0);
      idle();
      chk("lit.s_max", mx8, 8'h05);
      chk("lit.s_min", mn8, 8'hFA);
      chk("lit.model_min", frame_ext(1'b0), 8'hFA);

      // Mode mismatch: unsigned frame, then a signed sample; sticky.
      drive(1'b1, 8'd10, 8'd0, 1'b0, 1'b1);
      drive(1'b1, 8'd200, 8'd0, 1'b1, 1'b0);
      idle();
      chk("lit.mode_err", me8, 1'b1);
      chk("lit.merr_unsigned_max", mx8, 8'd200);
      drive(1'b1, 8'd15, 8'd0, 1'b0, 1'b0);
      idle();
      chk("lit.mode_err_sticky", me8, 1'b1);

      // Saturation on the 2-bit counter build, then clr with a sample.
      drive(1'b1, 8'd7, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
      idle();
      chk("lit.sat2", {sat2, cnt2}, 3'b111);
      chk("lit.cnt8_mid", cnt8, 8'd5);

      drive(1'b1, 8'd9, 8'd0, 1'b0, 1'b1);
      idle();
      chk("lit.clr_load", {mx8, mn8, cnt8}, {8'd9, 8'd9, 8'd1});
      chk("lit.clr_sticky", {me8, sat2, me2}, 3'b000);

      // Fresh frame of 5 samples: sat2 from the 4th.
      drive(1'b1, 8'd7, 8'd3, 1'b0, 1'b1);
      drive(1'b1, 8'd1, 8'd3, 1'b0, 1'b0);
      drive(1'b1, 8'd9, 8'd3, 1'b0, 1'b0);
      drive(1'b1, 8'd4, 8'd3, 1'b0, 1'b0);
      drive(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
      #1;
      chk("lit.sat_4th", {sat2, cnt2}, 3'b111);
      idle();
      chk("lit.sat_5th", {sat2, cnt2, cnt8}, {3'b111, 8'd5});
      chk("lit.sat_extremes", {mx2, mn2}, {8'd9, 8'd1});

      // clr alone empties the frame; compare flags untouched.
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      idle();
      chk("lit.clr_empty", {tv8, mx8, mn8, cnt8}, {1'b0, 24'd0});
      chk("lit.clr_flags_hold", {gt8, lt8, eq8}, 3'b010);

      // Signed boundaries in a short table.
      drive(1'b1, 8'h7F, 8'h80, 1'b1, 1'b0);
      drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
      drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
      idle();
      chk("lit.ff_unsigned_gt", {gt8, lt8, eq8}, 3'b100);

      // Asynchronous reset mid-frame.
      drive(1'b1, 8'd42, 8'd1, 1'b0, 1'b0);
      @(posedge Clk);
      #3 Rst = 1'b0;
      #1;
      chk("areset.all", {ov8, gt8, lt8, eq8, mx8, mn8, cnt8, sat8, tv8, me8},
          {4'b0000, 24'd0, 3'b000});
      in_valid = 1'b0;
      @(negedge Clk);
      #2 Rst = 1'b1;
      drive(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
      idle();
      chk("areset.first", {ov8, lt8, cnt8, mx8}, {2'b11, 8'd1, 8'd3});

      repeat (2) idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
